// File: rtl/rename_file_ckpt_if.sv
// Issue, commit, broadcast, branch-resolve and dispatch signals of the
// checkpointed rename file, bundled so the decoder side sees one port.
interface rename_file_ckpt_if #(
  parameter int DAT_W    = 32,
  parameter int REG_BIT  = 5,
  parameter int ROB_BIT  = 4,
  parameter int CKPT_BIT = 2,
  parameter int OP_W     = 6
);
  logic                en;
  logic                is_en_i, is_ic_i, is_br_i;
  logic [1:0]          is_tp_i;
  logic [REG_BIT-1:0]  is_rd_i, is_rs1_i, is_rs2_i;
  logic [OP_W-1:0]     is_op_i;
  logic [DAT_W-1:0]    is_imm_i, is_pc_i;
  logic [ROB_BIT-1:0]  rob_qd_i;
  logic                ckpt_full_o;
  logic [CKPT_BIT-1:0] ckpt_id_o;
  logic                rob_en_i;
  logic [REG_BIT-1:0]  rob_rd_i;
  logic [ROB_BIT-1:0]  rob_q_i;
  logic [DAT_W-1:0]    rob_v_i;
  logic [ROB_BIT-1:0]  rob_reqqj_o, rob_reqqk_o;
  logic                rob_rdyj_i, rob_rdyk_i;
  logic [DAT_W-1:0]    rob_rdyvj_i, rob_rdyvk_i;
  logic                cdb_en_i, ldb_en_i;
  logic [ROB_BIT-1:0]  cdb_q_i, ldb_q_i;
  logic [DAT_W-1:0]    cdb_v_i, ldb_v_i;
  logic                br_res_i, br_miss_i, flush_i;
  logic [CKPT_BIT-1:0] br_ckpt_i;
  logic                rs_en_o, lsb_en_o, ds_ic_o;
  logic [OP_W-1:0]     ds_op_o;
  logic [DAT_W-1:0]    ds_imm_o, ds_pc_o, ds_vj_o, ds_vk_o;
  logic [ROB_BIT-1:0]  ds_qj_o, ds_qk_o, ds_qd_o;

  modport master (
    output en, is_en_i, is_ic_i, is_br_i, is_tp_i, is_rd_i, is_rs1_i, is_rs2_i,
           is_op_i, is_imm_i, is_pc_i, rob_qd_i, rob_en_i, rob_rd_i, rob_q_i,
           rob_v_i, rob_rdyj_i, rob_rdyk_i, rob_rdyvj_i, rob_rdyvk_i, cdb_en_i,
           cdb_q_i, cdb_v_i, ldb_en_i, ldb_q_i, ldb_v_i, br_res_i, br_ckpt_i,
           br_miss_i, flush_i,
    input  ckpt_full_o, ckpt_id_o, rob_reqqj_o, rob_reqqk_o, rs_en_o, lsb_en_o,
           ds_ic_o, ds_op_o, ds_imm_o, ds_pc_o, ds_qj_o, ds_qk_o, ds_vj_o,
           ds_vk_o, ds_qd_o
  );

  modport slave (
    input  en, is_en_i, is_ic_i, is_br_i, is_tp_i, is_rd_i, is_rs1_i, is_rs2_i,
           is_op_i, is_imm_i, is_pc_i, rob_qd_i, rob_en_i, rob_rd_i, rob_q_i,
           rob_v_i, rob_rdyj_i, rob_rdyk_i, rob_rdyvj_i, rob_rdyvk_i, cdb_en_i,
           cdb_q_i, cdb_v_i, ldb_en_i, ldb_q_i, ldb_v_i, br_res_i, br_ckpt_i,
           br_miss_i, flush_i,
    output ckpt_full_o, ckpt_id_o, rob_reqqj_o, rob_reqqk_o, rs_en_o, lsb_en_o,
           ds_ic_o, ds_op_o, ds_imm_o, ds_pc_o, ds_qj_o, ds_qk_o, ds_vj_o,
           ds_vk_o, ds_qd_o
  );
endinterface

// File: rtl/rename_file_ckpt.sv
// Register file plus ROB-tag rename map with CKPT_N branch snapshots that
// restore the map on a mispredict; branches may resolve out of order.
module rename_file_ckpt #(
  parameter int DAT_W    = 32,
  parameter int REG_S    = 32,
  parameter int REG_BIT  = 5,
  parameter int ROB_BIT  = 4,
  parameter int CKPT_N   = 4,
  parameter int CKPT_BIT = 2,
  parameter int OP_W     = 6
) (
  input logic               clk,
  input logic               rst,
  rename_file_ckpt_if.slave bus
);
  localparam logic [CKPT_BIT:0] FULL_CNT = CKPT_N[CKPT_BIT:0];

  logic [DAT_W-1:0]   regs_reg [REG_S];
  logic [DAT_W-1:0]   regs_next [REG_S];
  logic [ROB_BIT-1:0] q_reg [REG_S];
  logic [ROB_BIT-1:0] q_next [REG_S];
  logic [ROB_BIT-1:0] snap_reg [CKPT_N][REG_S];
  logic [ROB_BIT-1:0] snap_next [CKPT_N][REG_S];
  logic [CKPT_N-1:0]  valid_reg, valid_next;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CKPT_BIT:0]  head_reg, head_next, tail_reg, tail_next, count;
  logic [CKPT_N-1:0][CKPT_BIT-1:0] slot_age;
  logic [CKPT_BIT-1:0] d_b;

  logic rs_en_reg, lsb_en_reg, ds_ic_reg;
  logic [OP_W-1:0]    ds_op_reg;
  logic [DAT_W-1:0]   ds_imm_reg, ds_pc_reg, ds_vj_reg, ds_vk_reg;
  logic [ROB_BIT-1:0] ds_qj_reg, ds_qk_reg, ds_qd_reg;

  logic full, mispredict, resolve_ok, commit, issue_ok, ckpt_take, rename, to_lsb;

  assign count      = tail_reg - head_reg;
  assign full       = (count == FULL_CNT);
  assign mispredict = bus.en && !bus.flush_i && bus.br_res_i && bus.br_miss_i;
  assign resolve_ok = bus.en && !bus.flush_i && bus.br_res_i && !bus.br_miss_i;
  assign commit     = bus.en && !bus.flush_i && bus.rob_en_i;
  assign issue_ok   = bus.en && !bus.flush_i && bus.is_en_i && !mispredict &&
                      !(bus.is_br_i && full);
  assign ckpt_take  = issue_ok && bus.is_br_i;
  assign rename     = issue_ok && (bus.is_rd_i != '0);
  assign to_lsb     = (bus.is_tp_i == 2'b01) || (bus.is_tp_i == 2'b10);
  assign d_b        = bus.br_ckpt_i - head_reg[CKPT_BIT-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < CKPT_N; gi++) begin : g_age
      assign slot_age[gi] = CKPT_BIT'(gi) - head_reg[CKPT_BIT-1:0];
    end
  endgenerate

  // Operand lookup: later sources in the chain override earlier ones.
  logic [1:0][REG_BIT-1:0] rs_idx;
  logic [1:0]              rdy;
  logic [1:0][DAT_W-1:0]   rdy_v, fw_v;
  logic [1:0][ROB_BIT-1:0] fw_q;
  assign rs_idx = {bus.is_rs2_i, bus.is_rs1_i};
  assign rdy    = {bus.rob_rdyk_i, bus.rob_rdyj_i};
  assign rdy_v  = {bus.rob_rdyvk_i, bus.rob_rdyvj_i};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [ROB_BIT-1:0] lk_q;
      logic hit_c, hit_l, hit_b, hit_r;
      assign lk_q  = q_reg[rs_idx[gi]];
      assign hit_c = (lk_q != '0) && bus.rob_en_i && (bus.rob_q_i == lk_q);
      assign hit_l = (lk_q != '0) && bus.ldb_en_i && (bus.ldb_q_i == lk_q);
      assign hit_b = (lk_q != '0) && bus.cdb_en_i && (bus.cdb_q_i == lk_q);
      assign hit_r = (lk_q != '0) && rdy[gi];
      assign fw_v[gi] = hit_r ? rdy_v[gi] : hit_b ? bus.cdb_v_i :
                        hit_l ? bus.ldb_v_i : hit_c ? bus.rob_v_i :
                        regs_reg[rs_idx[gi]];
      assign fw_q[gi] = (hit_c || hit_l || hit_b || hit_r) ? '0 : lk_q;
    end
  endgenerate

  always_comb begin
    for (int r = 0; r < REG_S; r++) begin
      regs_next[r] = regs_reg[r];
      q_next[r]    = mispredict ? snap_reg[bus.br_ckpt_i][r] : q_reg[r];
    end
    if (commit) begin
      regs_next[bus.rob_rd_i] = bus.rob_v_i;
      if (q_next[bus.rob_rd_i] == bus.rob_q_i) q_next[bus.rob_rd_i] = '0;
    end
    if (rename) q_next[bus.is_rd_i] = bus.rob_qd_i;
    regs_next[0] = '0;
    q_next[0]    = '0;

    for (int s = 0; s < CKPT_N; s++) begin
      for (int r = 0; r < REG_S; r++) snap_next[s][r] = snap_reg[s][r];
      if (commit && valid_reg[s] && snap_reg[s][bus.rob_rd_i] == bus.rob_q_i)
        snap_next[s][bus.rob_rd_i] = '0;
      if (ckpt_take && tail_reg[CKPT_BIT-1:0] == CKPT_BIT'(s))
        for (int r = 0; r < REG_S; r++) snap_next[s][r] = q_next[r];
    end

    valid_next = valid_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (resolve_ok) valid_next[bus.br_ckpt_i] = 1'b0;
    if (mispredict) begin
      // Kill the mispredicted branch and everything allocated after it.
      for (int s = 0; s < CKPT_N; s++)
        if (slot_age[s] >= d_b && {1'b0, slot_age[s]} < count) valid_next[s] = 1'b0;
      tail_next = head_reg + {1'b0, d_b} + 1'b1;
    end
    if (ckpt_take) begin
      valid_next[tail_reg[CKPT_BIT-1:0]] = 1'b1;
      tail_next = tail_reg + 1'b1;
    end
    if (bus.en && head_reg != tail_reg && !valid_reg[head_reg[CKPT_BIT-1:0]])
      head_next = head_reg + 1'b1;

    if (bus.flush_i) begin
      for (int r = 0; r < REG_S; r++) q_next[r] = '0;
      valid_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_S; r++) begin
        regs_reg[r] <= '0;
        q_reg[r]    <= '0;
        for (int s = 0; s < CKPT_N; s++) snap_reg[s][r] <= '0;
      end
      valid_reg  <= '0;
      head_reg   <= '0;
      tail_reg   <= '0;
      rs_en_reg  <= 1'b0;
      lsb_en_reg <= 1'b0;
      ds_ic_reg  <= 1'b0;
      ds_op_reg  <= '0;
      ds_imm_reg <= '0;
      ds_pc_reg  <= '0;
      ds_qj_reg  <= '0;
      ds_qk_reg  <= '0;
      ds_vj_reg  <= '0;
      ds_vk_reg  <= '0;
      ds_qd_reg  <= '0;
    end else begin
      for (int r = 0; r < REG_S; r++) begin
        regs_reg[r] <= regs_next[r];
        q_reg[r]    <= q_next[r];
        for (int s = 0; s < CKPT_N; s++) snap_reg[s][r] <= snap_next[s][r];
      end
      valid_reg  <= valid_next;
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      rs_en_reg  <= issue_ok && !to_lsb;
      lsb_en_reg <= issue_ok && to_lsb;
      if (issue_ok) begin
        ds_ic_reg  <= bus.is_ic_i;
        ds_op_reg  <= bus.is_op_i;
        ds_imm_reg <= bus.is_imm_i;
        ds_pc_reg  <= bus.is_pc_i;
        ds_qj_reg  <= fw_q[0];
        ds_qk_reg  <= fw_q[1];
        ds_vj_reg  <= fw_v[0];
        ds_vk_reg  <= fw_v[1];
        ds_qd_reg  <= bus.rob_qd_i;
      end
    end
  end

  assign bus.ckpt_full_o = full;
  assign bus.ckpt_id_o   = tail_reg[CKPT_BIT-1:0];
  assign bus.rob_reqqj_o = q_reg[bus.is_rs1_i];
  assign bus.rob_reqqk_o = q_reg[bus.is_rs2_i];
  assign bus.rs_en_o     = rs_en_reg;
  assign bus.lsb_en_o    = lsb_en_reg;
  assign bus.ds_ic_o     = ds_ic_reg;
  assign bus.ds_op_o     = ds_op_reg;
  assign bus.ds_imm_o    = ds_imm_reg;
  assign bus.ds_pc_o     = ds_pc_reg;
  assign bus.ds_qj_o     = ds_qj_reg;
  assign bus.ds_qk_o     = ds_qk_reg;
  assign bus.ds_vj_o     = ds_vj_reg;
  assign bus.ds_vk_o     = ds_vk_reg;
  assign bus.ds_qd_o     = ds_qd_reg;
endmodule

// File: tb/tb_rename_file_ckpt.sv
// Directed bench for rename_file_ckpt: rename, forwarding, checkpoint
// allocate/resolve/restore, flush and asynchronous reset.
module tb_rename_file_ckpt;
  localparam int DAT_W = 32, REG_S = 32, REG_BIT = 5, ROB_BIT = 4;
  localparam int CKPT_N = 4, CKPT_BIT = 2, OP_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rename_file_ckpt_if #(.DAT_W(DAT_W), .REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT),
                        .CKPT_BIT(CKPT_BIT), .OP_W(OP_W)) bus ();

  rename_file_ckpt #(.DAT_W(DAT_W), .REG_S(REG_S), .REG_BIT(REG_BIT), .ROB_BIT(ROB_BIT),
                     .CKPT_N(CKPT_N), .CKPT_BIT(CKPT_BIT), .OP_W(OP_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    bus.is_en_i = 0; bus.is_br_i = 0; bus.rob_en_i = 0; bus.cdb_en_i = 0;
    bus.ldb_en_i = 0; bus.rob_rdyj_i = 0; bus.rob_rdyk_i = 0;
    bus.br_res_i = 0; bus.br_miss_i = 0; bus.flush_i = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [3:0] tag, input logic br, input logic [1:0] tp);
    bus.is_en_i = 1; bus.is_rd_i = rd; bus.is_rs1_i = rs1; bus.is_rs2_i = rs2;
    bus.rob_qd_i = tag; bus.is_br_i = br; bus.is_tp_i = tp; bus.is_ic_i = tag[0];
    bus.is_op_i = OP_W'(tag); bus.is_imm_i = 32'h100 + 32'(tag);
    bus.is_pc_i = 32'h40 + 32'(tag) * 4;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
    bus.rob_en_i = 1; bus.rob_rd_i = rd; bus.rob_q_i = tag; bus.rob_v_i = v;
  endtask

  task automatic resolve(input logic [1:0] id, input logic miss);
    bus.br_res_i = 1; bus.br_ckpt_i = id; bus.br_miss_i = miss;
  endtask

  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("txn %s", what);
    clear_strobes();
  endtask

  // Reads the current tag of one register through the combinational request port.
  task automatic chk_q(input string tag, input logic [4:0] r, input logic [3:0] exp);
    bus.is_rs1_i = r;
    #1;
    check(tag, 64'(bus.rob_reqqj_o), 64'(exp));
  endtask

  initial begin
    bus.en = 1; clear_strobes();
    bus.is_rd_i = 0; bus.is_rs1_i = 0; bus.is_rs2_i = 0; bus.rob_qd_i = 0;
    bus.is_tp_i = 0; bus.is_ic_i = 0; bus.is_op_i = 0; bus.is_imm_i = 0; bus.is_pc_i = 0;
    bus.rob_rd_i = 0; bus.rob_q_i = 0; bus.rob_v_i = 0; bus.rob_rdyvj_i = 0;
    bus.rob_rdyvk_i = 0; bus.cdb_q_i = 0; bus.cdb_v_i = 0; bus.ldb_q_i = 0;
    bus.ldb_v_i = 0; bus.br_ckpt_i = 0;

    #12;
    check("rst_rs_en", 64'(bus.rs_en_o), 64'(0));
    check("rst_lsb_en", 64'(bus.lsb_en_o), 64'(0));
    check("rst_qd", 64'(bus.ds_qd_o), 64'(0));
    check("rst_full", 64'(bus.ckpt_full_o), 64'(0));
    check("rst_id", 64'(bus.ckpt_id_o), 64'(0));
    @(negedge clk); rst = 1;

    // Basic rename and dispatch payload
    issue(5, 1, 2, 4'd3, 0, 2'b00); step("issue x5 tag3");
    check("b1_rs_en", 64'(bus.rs_en_o), 64'(1));
    check("b1_lsb_en", 64'(bus.lsb_en_o), 64'(0));
    check("b1_qd", 64'(bus.ds_qd_o), 64'(3));
    check("b1_qj", 64'(bus.ds_qj_o), 64'(0));
    check("b1_ic", 64'(bus.ds_ic_o), 64'(1));
    check("b1_op", 64'(bus.ds_op_o), 64'(3));
    check("b1_imm", 64'(bus.ds_imm_o), 64'h103);
    check("b1_pc", 64'(bus.ds_pc_o), 64'h4c);
    issue(6, 5, 0, 4'd4, 0, 2'b01); step("issue x6=x5+x0 tag4 lsb");
    check("b2_rs_en", 64'(bus.rs_en_o), 64'(0));
    check("b2_lsb_en", 64'(bus.lsb_en_o), 64'(1));
    check("b2_qj", 64'(bus.ds_qj_o), 64'(3));
    check("b2_qk", 64'(bus.ds_qk_o), 64'(0));
    commit(5, 4'd3, 32'h10); step("commit x5=0x10 tag3");
    check("b3_lsb_idle", 64'(bus.lsb_en_o), 64'(0));
    chk_q("b3_q5", 5, 4'd0);
    chk_q("b3_q6", 6, 4'd4);
    issue(0, 5, 6, 4'd5, 0, 2'b11); step("issue read x5,x6 tp11");
    check("b4_rs_en", 64'(bus.rs_en_o), 64'(1));
    check("b4_vj", 64'(bus.ds_vj_o), 64'h10);
    check("b4_qj", 64'(bus.ds_qj_o), 64'(0));
    check("b4_qk", 64'(bus.ds_qk_o), 64'(4));
    chk_q("b4_q0", 0, 4'd0);

    // Forwarding priority: ROB-ready > CDB > LDB > commit
    issue(7, 0, 0, 4'd2, 0, 2'b00); step("issue x7 tag2");
    issue(8, 7, 7, 4'd6, 0, 2'b10);
    bus.cdb_en_i = 1; bus.cdb_q_i = 2; bus.cdb_v_i = 32'hAA;
    bus.ldb_en_i = 1; bus.ldb_q_i = 2; bus.ldb_v_i = 32'hCC;
    bus.rob_rdyj_i = 1; bus.rob_rdyvj_i = 32'hBB;
    step("issue x8 with cdb/ldb/rdyj");
    check("f1_qj", 64'(bus.ds_qj_o), 64'(0));
    check("f1_vj", 64'(bus.ds_vj_o), 64'hBB);
    check("f1_qk", 64'(bus.ds_qk_o), 64'(0));
    check("f1_vk", 64'(bus.ds_vk_o), 64'hAA);
    issue(0, 7, 8, 4'd1, 0, 2'b00); commit(7, 4'd2, 32'h77);
    bus.ldb_en_i = 1; bus.ldb_q_i = 6; bus.ldb_v_i = 32'h66;
    step("issue read x7,x8 with commit and ldb");
    check("f2_vj", 64'(bus.ds_vj_o), 64'h77);
    check("f2_vk", 64'(bus.ds_vk_o), 64'h66);
    chk_q("f2_q7", 7, 4'd0);
    chk_q("f2_q8", 8, 4'd6);

    // Mispredict restore
    issue(5, 0, 0, 4'd3, 0, 2'b00); step("issue x5 tag3");
    check("m_id0", 64'(bus.ckpt_id_o), 64'(0));
    issue(0, 0, 0, 4'd9, 1, 2'b00); step("branch ckpt0");
    check("m_id1", 64'(bus.ckpt_id_o), 64'(1));
    issue(5, 0, 0, 4'd7, 0, 2'b00); step("issue x5 tag7");
    chk_q("m_q5_new", 5, 4'd7);
    issue(8, 0, 0, 4'd10, 0, 2'b00); step("issue x8 tag10");
    resolve(0, 1); issue(8, 0, 0, 4'd12, 0, 2'b00); step("mispredict ckpt0 + ignored issue");
    check("m_rs_en", 64'(bus.rs_en_o), 64'(0));
    check("m_tail", 64'(bus.ckpt_id_o), 64'(1));
    chk_q("m_q5", 5, 4'd3);
    chk_q("m_q8", 8, 4'd6);
    chk_q("m_q6", 6, 4'd4);

    // Flush keeps register values
    bus.flush_i = 1; issue(11, 0, 0, 4'd11, 0, 2'b00); step("flush");
    check("fl_rs_en", 64'(bus.rs_en_o), 64'(0));
    check("fl_id", 64'(bus.ckpt_id_o), 64'(0));
    chk_q("fl_q5", 5, 4'd0);
    chk_q("fl_q11", 11, 4'd0);
    issue(0, 5, 7, 4'd1, 0, 2'b00); step("issue read x5,x7");
    check("fl_vj", 64'(bus.ds_vj_o), 64'h10);
    check("fl_vk", 64'(bus.ds_vk_o), 64'h77);

    // Fill checkpoints, then resolve out of order
    for (int k = 1; k <= 4; k++) begin
      issue(0, 0, 0, 4'(k), 1, 2'b00); step("branch");
      check("cf_id", 64'(bus.ckpt_id_o), 64'(k % 4));
      check("cf_full", 64'(bus.ckpt_full_o), 64'(k == 4));
    end
    issue(10, 0, 0, 4'd13, 1, 2'b00); step("branch while full");
    check("cf_drop_en", 64'(bus.rs_en_o), 64'(0));
    check("cf_drop_id", 64'(bus.ckpt_id_o), 64'(0));
    chk_q("cf_drop_q10", 10, 4'd0);
    resolve(2, 0); step("resolve ckpt2 ok");
    check("cf_r2_full", 64'(bus.ckpt_full_o), 64'(1));
    resolve(0, 0); step("resolve ckpt0 ok");
    check("cf_r0_full", 64'(bus.ckpt_full_o), 64'(1));
    step("idle");
    check("cf_head_full", 64'(bus.ckpt_full_o), 64'(0));
    issue(0, 0, 0, 4'd14, 1, 2'b00); step("branch after head move");
    check("cf_refill_full", 64'(bus.ckpt_full_o), 64'(1));
    check("cf_refill_id", 64'(bus.ckpt_id_o), 64'(1));
    bus.flush_i = 1; step("flush");

    // Commit scrubs a live snapshot
    issue(9, 0, 0, 4'd4, 0, 2'b00); step("issue x9 tag4");
    issue(0, 0, 0, 4'd5, 1, 2'b00); step("branch ckpt0");
    issue(9, 0, 0, 4'd6, 0, 2'b00); step("issue x9 tag6");
    commit(9, 4'd4, 32'h99); step("commit x9 tag4");
    chk_q("s_q9_live", 9, 4'd6);
    resolve(0, 1); step("mispredict ckpt0");
    chk_q("s_q9", 9, 4'd0);
    issue(0, 9, 0, 4'd1, 0, 2'b00); commit(0, 4'd0, 32'h55); step("read x9, commit x0");
    check("s_vj", 64'(bus.ds_vj_o), 64'h99);
    issue(0, 0, 0, 4'd2, 0, 2'b00); step("read x0");
    check("x0_v", 64'(bus.ds_vj_o), 64'(0));

    // Stall gate
    bus.en = 0; issue(12, 0, 0, 4'd8, 0, 2'b00); step("issue while stalled");
    check("en_rs_en", 64'(bus.rs_en_o), 64'(0));
    chk_q("en_q12", 12, 4'd0);
    bus.en = 1;

    // Asynchronous reset between edges
    issue(0, 0, 0, 4'd3, 1, 2'b00); step("branch before reset");
    check("ar_rs_en_pre", 64'(bus.rs_en_o), 64'(1));
    check("ar_id_pre", 64'(bus.ckpt_id_o), 64'(2));
    #2; rst = 0; #1;
    check("ar_rs_en", 64'(bus.rs_en_o), 64'(0));
    check("ar_id", 64'(bus.ckpt_id_o), 64'(0));
    check("ar_qd", 64'(bus.ds_qd_o), 64'(0));
    @(negedge clk); rst = 1;
    step("idle after reset");
    check("ar_full", 64'(bus.ckpt_full_o), 64'(0));
    chk_q("ar_q9", 9, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
